// File: rtl/ram_sdp_clr.sv
// Simple-dual-port synchronous RAM with a registered read port, a read-valid
// strobe and a post-reset clear sequencer that writes INIT_VAL to every word.
// Optional macro RAM_BYPASS_EN selects write-first on a same-address collision
// (default build is read-first).
module ram_sdp_clr #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 9,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_addr, clr_addr_nxt;

  // Storage is never reset; only the sweep initialises it.
  logic [DATA_W-1:0]   mem [DEPTH];

  // Unified memory write port: sweep writes during CLEAR, user writes in IDLE.
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                rd_en;
  logic                collide;

  // State register and clear-address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // Next-state logic and memory write-port steering.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    mem_we       = 1'b0;
    mem_waddr    = waddr;
    mem_wdata    = wdata;
    rd_en        = 1'b0;
    case (state)
      CLEAR: begin
        mem_we    = ~rst;
        mem_waddr = clr_addr;
        mem_wdata = INIT_VAL;
        if (clr_addr == LAST_ADDR) begin
          state_nxt    = IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + 1'b1;
        end
      end
      IDLE: begin
        // Reset wins over a port access presented at the same edge.
        mem_we = we & ~rst;
        rd_en  = re & ~rst;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  assign busy    = (state == CLEAR);
  assign collide = mem_we && (state == IDLE) && (waddr == raddr);

  // Memory array write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read data and valid strobe; rdata holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
`ifdef RAM_BYPASS_EN
        // Write-first: a colliding write is forwarded to the read port.
        rdata <= collide ? wdata : mem[raddr];
`else
        // Read-first: the old word is returned; the write still lands.
        rdata <= mem[raddr];
`endif
      end
    end
  end

`ifndef RAM_BYPASS_EN
  // Collision detect only matters for the forwarding build.
  logic unused_collide;
  assign unused_collide = collide;
`endif

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Directed testbench for ram_sdp_clr (DATA_W=16, ADDR_W=9, INIT_VAL=16'hA5A5).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ram_sdp_clr;

  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 9;
  localparam logic [15:0] INIT   = 16'hA5A5;

  logic              clk;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;

  int checks = 0;
  int errors = 0;

  ram_sdp_clr #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .INIT_VAL(INIT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata),
    .rvalid(rvalid),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for busy to drop; returns the number of rising edges observed.
  task automatic wait_clear(output int edges);
    edges = 0;
    while (busy === 1'b1 && edges < 2000) begin
      @(negedge clk);
      edges++;
    end
  endtask

  // Pulse reset for n cycles, release, and return edges until busy falls.
  task automatic do_clear(input int n, output int edges);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    wait_clear(edges);
  endtask

  // Issue a single read and capture the result one cycle later.
  task automatic read_word(input logic [ADDR_W-1:0] a,
                           output logic [DATA_W-1:0] d, output logic v);
    re    = 1'b1;
    raddr = a;
    @(negedge clk);
    d  = rdata;
    v  = rvalid;
    re = 1'b0;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rvalid !== 1'b0 || rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: busy=%b rvalid=%b rdata=%h, need busy=1 rvalid=0 rdata=0000",
               busy, rvalid, rdata);
    end
  endtask

  task automatic test_clear;
    int edges;
    logic [DATA_W-1:0] d;
    logic v;
    logic [ADDR_W-1:0] addrs [3];
    addrs[0] = 9'd0;
    addrs[1] = 9'd255;
    addrs[2] = 9'd511;
    rst = 1'b0;
    wait_clear(edges);
    checks++;
    if (edges != 512) begin
      errors++;
      $display("FAIL clear_len: busy fell after %0d edges, need 512", edges);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rvalid !== 1'b0) begin
        errors++;
        $display("FAIL clear_pre_rvalid[%0d]: rvalid=%b, need 0", i, rvalid);
      end
      read_word(addrs[i], d, v);
      checks++;
      if (d !== INIT || v !== 1'b1) begin
        errors++;
        $display("FAIL clear_read[%0d]: rdata=%h rvalid=%b, need %h and 1", addrs[i], d, v, INIT);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write_read;
    logic [DATA_W-1:0] exp [4];
    exp[0] = 16'd10;
    exp[1] = 16'd20;
    exp[2] = 16'd30;
    exp[3] = 16'd40;
    for (int i = 0; i < 4; i++) write_word(ADDR_W'(i), exp[i]);
    re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      raddr = ADDR_W'(i);
      @(negedge clk);
      checks++;
      if (rdata !== exp[i] || rvalid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_read[%0d]: rdata=%0d rvalid=%b, need %0d and 1", i, rdata, rvalid, exp[i]);
      end
    end
    re = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 16'd40) begin
      errors++;
      $display("FAIL b2b_tail: rvalid=%b rdata=%0d, need 0 and held 40", rvalid, rdata);
    end
  endtask

  task automatic test_collision;
    logic [DATA_W-1:0] d;
    logic v;
    logic [DATA_W-1:0] exp_col;
`ifdef RAM_BYPASS_EN
    exp_col = 16'd99;
`else
    exp_col = 16'd7;
`endif
    write_word(9'd5, 16'd7);
    we    = 1'b1;
    waddr = 9'd5;
    wdata = 16'd99;
    re    = 1'b1;
    raddr = 9'd5;
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
    checks++;
    if (rdata !== exp_col || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL collision: rdata=%0d rvalid=%b, need %0d and 1", rdata, rvalid, exp_col);
    end
    read_word(9'd5, d, v);
    checks++;
    if (d !== 16'd99 || v !== 1'b1) begin
      errors++;
      $display("FAIL collision_followup: rdata=%0d rvalid=%b, need 99 and 1", d, v);
    end
  endtask

  task automatic test_busy_lockout;
    int edges;
    int bad_rvalid;
    logic [DATA_W-1:0] d;
    logic v;
    bad_rvalid = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    we    = 1'b1;
    waddr = 9'd3;
    wdata = 16'd1234;
    re    = 1'b1;
    raddr = 9'd3;
    edges = 0;
    while (busy === 1'b1 && edges < 2000) begin
      @(negedge clk);
      edges++;
      if (rvalid !== 1'b0) bad_rvalid++;
    end
    we = 1'b0;
    re = 1'b0;
    checks++;
    if (bad_rvalid != 0 || edges != 512) begin
      errors++;
      $display("FAIL lockout: rvalid high %0d times, clear took %0d edges, need 0 and 512",
               bad_rvalid, edges);
    end
    @(negedge clk);
    read_word(9'd3, d, v);
    checks++;
    if (d !== INIT || v !== 1'b1) begin
      errors++;
      $display("FAIL lockout_read: rdata=%h rvalid=%b, need %h and 1", d, v, INIT);
    end
  endtask

  task automatic test_reset_mid_clear;
    int edges;
    int bad_out;
    bad_out = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midclear_busy: busy=%b, need 1", busy);
    end
    rst   = 1'b0;
    edges = 0;
    while (busy === 1'b1 && edges < 2000) begin
      if (rvalid !== 1'b0 || rdata !== 16'h0000) bad_out++;
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges != 512 || bad_out != 0) begin
      errors++;
      $display("FAIL midclear: busy fell after %0d edges with %0d nonzero outputs, need 512 and 0",
               edges, bad_out);
    end
  endtask

  task automatic test_boundary;
    logic [DATA_W-1:0] d;
    logic v;
    write_word(9'd511, 16'hFFFF);
    write_word(9'd0, 16'h0001);
    read_word(9'd511, d, v);
    checks++;
    if (d !== 16'hFFFF || v !== 1'b1) begin
      errors++;
      $display("FAIL boundary_511: rdata=%h rvalid=%b, need ffff and 1", d, v);
    end
    read_word(9'd0, d, v);
    checks++;
    if (d !== 16'h0001 || v !== 1'b1) begin
      errors++;
      $display("FAIL boundary_0: rdata=%h rvalid=%b, need 0001 and 1", d, v);
    end
    read_word(9'd1, d, v);
    checks++;
    if (d !== 16'd20) begin
      errors++;
      $display("FAIL boundary_neighbour: rdata=%0d, need 20", d);
    end
  endtask

  initial begin
    rst   = 1'b0;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    re    = 1'b0;
    raddr = '0;
    test_reset;
    test_clear;
    test_write_read;
    test_collision;
    test_boundary;
    test_busy_lockout;
    test_reset_mid_clear;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
